dco_bank_slew_cod: RTL and testbench
====================================

# dco_bank_slew_cod

Parametrised, slew-limited row/column encoder for the DCO capacitor bank. It accepts a binary tuning word over a valid/ready handshake. It walks an internal current code toward that word by at most MAX_STEP LSBs per clock. Each step is decoded into registered active-low row-all, one-hot row and serpentine thermometer column selects that drive the bank. The block sits between the ADPLL tuning-word path and the DCO bank, and replaces the fixed-size, unlimited-jump row/column coder.

## Interface
- WORD_W, 8: tuning word width; must equal ROW_W + COL_W
- ROW_W, 4: log2 number of rows (NROW = 2^ROW_W)
- COL_W, 4: log2 number of columns (NCOL = 2^COL_W)
- MAX_STEP, 16: maximum code change per update edge; 0 = unlimited (single-edge jump)
- RST_WORD, 2^(WORD_W-1): code loaded at reset

- clk  in  1  clock; all state updates on the falling edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- en  in  1  update enable; low freezes all state
- word_vld  in  1  new target word valid
- word  in  WORD_W  target tuning word
- word_rdy  out  1  target can be accepted (current code == target)
- busy  out  1  slewing in progress (= !word_rdy)
- step  out  1  one-cycle pulse: current code changed on this edge
- cur_word  out  WORD_W  current applied code
- r_all  out  NROW  active-low full-row enables
- row  out  NROW  one-hot partial row select
- col  out  NCOL  thermometer column select within the partial row

## Operation
- State: cur (WORD_W), tgt (WORD_W); all outputs registered and decoded from the next value of cur, so they stay consistent with cur_word every cycle.
- Accept: on an edge with en & word_vld & word_rdy, tgt <= word; the first step toward word happens on the same edge.
- word_vld while busy is ignored; there is no queuing, and word is not sampled.
- Step: d = target - cur, where target is the accepted word on an accept edge and tgt otherwise.
  - If MAX_STEP == 0 or |d| <= MAX_STEP: cur <= target.
  - Otherwise: cur <= cur ± MAX_STEP, sign of d.
  - Arithmetic is unsigned with no wrap: a step never passes target.
- Decode of code c:
  - ri = c >> COL_W; cc = c mod NCOL.
  - r_all[i] = 0 for i < ri, else 1.
  - row[i] = (i == ri).
  - ri even: col[i] = (i < cc).
  - ri odd: col[i] = (i >= NCOL - cc). This serpentine direction makes adjacent codes differ in one column cell.
- step = 1 on edges where cur changes; otherwise 0.
- en low: cur, tgt, step (forced 0) and all decoded outputs hold; handshake is stalled.

## Timing
- Reset (rst_n low at a falling edge): cur = tgt = RST_WORD, word_rdy = 1, busy = 0, step = 0.
  - Default 8/4/4 reset outputs: r_all = 0xFF00, row = 0x0100, col = 0x0000, cur_word = 0x80.
- Reset mid-slew aborts the slew and overrides en and word_vld.
- Latency: N = ceil(|word - cur| / MAX_STEP) edges, counting the accept edge. N = 1 when MAX_STEP = 0 or d ≤ MAX_STEP. word_rdy rises on the edge cur reaches tgt.
- A new word can be accepted on the edge immediately after word_rdy = 1 is observed (back-to-back).
- Accepting word == cur: no step pulse, and word_rdy stays 1.
- Boundaries: code 0 gives r_all all-1, row[0] = 1, col = 0. Code 2^WORD_W - 1 gives r_all = only MSB 1, row MSB, col per ri parity.

## Test plan
Default parameters unless noted.
1. Reset: hold rst_n = 0 for 2 edges → r_all = 0xFF00, row = 0x0100, col = 0x0000, cur_word = 0x80, word_rdy = 1, step = 0.
2. Up slew: word = 0x93 with vld → cur = 0x90 on edge 1 (busy = 1), cur = 0x93 on edge 2. Final r_all = 0xFE00, row = 0x0200, col = 0xE000 (odd row); step high on both edges.
3. Down slew from 0x80: word = 0x25 → cur sequence 0x70, 0x60, 0x50, 0x40, 0x30, 0x25 over 6 edges. Final r_all = 0xFFFC, row = 0x0004, col = 0x001F.
4. Handshake/stall: during test 3, assert word_vld with 0xFF → ignored, word_rdy = 0. Drop en for 3 edges mid-slew → cur and outputs frozen, step = 0. Slew resumes and ends at 0x25.
5. Reset mid-slew: rst_n = 0 at slew edge 3 → next edge returns the reset values of test 1; old target discarded.
6. MAX_STEP = 0: word = 0xFF → single edge to r_all = 0x8000, row = 0x8000, col = 0xFFFE. Then word = 0x00 → r_all = 0xFFFF, row = 0x0001, col = 0x0000 in one edge.

Source files
------------

// File: rtl/dco_bank_slew_cod.sv
// -----------------------------------------------------------------------------
// dco_bank_slew_cod
//
// Slew-limited row/column encoder for the DCO capacitor bank. A binary tuning
// word is accepted over a valid/ready handshake; the applied code then walks
// toward it by at most MAX_STEP LSBs per update edge. Every applied code is
// decoded into registered active-low full-row enables, a one-hot partial-row
// select and a serpentine thermometer column select.
//
// All state updates on the FALLING edge of clk_i. WORD_W must equal
// ROW_W + COL_W.
//
// Ports:
//   clk_i        clock (state updates on falling edge)
//   rst_ni       synchronous active-low reset
//   en_i         update enable; low freezes all state
//   word_vld_i   new target word valid
//   word_i       target tuning word
//   word_rdy_o   target can be accepted (current code == target)
//   busy_o       slewing in progress (= !word_rdy_o)
//   step_o       one-cycle pulse: current code changed on this edge
//   cur_word_o   currently applied code
//   r_all_o      active-low full-row enables (NROW)
//   row_o        one-hot partial row select (NROW)
//   col_o        thermometer column select within the partial row (NCOL)
// -----------------------------------------------------------------------------
module dco_bank_slew_cod #(
    parameter int WORD_W   = 8,
    parameter int ROW_W    = 4,
    parameter int COL_W    = 4,
    parameter int MAX_STEP = 16,
    parameter int RST_WORD = 2 ** (WORD_W - 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      word_vld_i,
    input  logic [WORD_W-1:0]         word_i,
    output logic                      word_rdy_o,
    output logic                      busy_o,
    output logic                      step_o,
    output logic [WORD_W-1:0]         cur_word_o,
    output logic [(2**ROW_W)-1:0]     r_all_o,
    output logic [(2**ROW_W)-1:0]     row_o,
    output logic [(2**COL_W)-1:0]     col_o
);

    localparam int NROW = 2 ** ROW_W;
    localparam int NCOL = 2 ** COL_W;

    localparam logic [WORD_W-1:0] RST_C  = WORD_W'(RST_WORD);
    localparam logic [WORD_W-1:0] STEP_C = WORD_W'(MAX_STEP);

    // ------------------------------------------------------------------
    // Decode helpers (also used to build the reset values of the outputs)
    // ------------------------------------------------------------------
    function automatic logic [NROW-1:0] dec_r_all(input logic [WORD_W-1:0] c);
        logic [NROW-1:0] r;
        int ri;
        ri = int'(c[WORD_W-1:COL_W]);
        r  = '0;
        for (int i = 0; i < NROW; i++) begin
            r[i] = (i >= ri);
        end
        return r;
    endfunction

    function automatic logic [NROW-1:0] dec_row(input logic [WORD_W-1:0] c);
        logic [NROW-1:0] r;
        int ri;
        ri = int'(c[WORD_W-1:COL_W]);
        r  = '0;
        for (int i = 0; i < NROW; i++) begin
            r[i] = (i == ri);
        end
        return r;
    endfunction

    // Odd rows fill from the top column down, so stepping across a row
    // boundary only ever toggles a single column cell.
    function automatic logic [NCOL-1:0] dec_col(input logic [WORD_W-1:0] c);
        logic [NCOL-1:0] r;
        int cc;
        logic odd;
        cc  = int'(c[COL_W-1:0]);
        odd = c[COL_W];
        r   = '0;
        for (int i = 0; i < NCOL; i++) begin
            r[i] = odd ? (i >= NCOL - cc) : (i < cc);
        end
        return r;
    endfunction

    localparam logic [NROW-1:0] RST_R_ALL = dec_r_all(RST_C);
    localparam logic [NROW-1:0] RST_ROW   = dec_row(RST_C);
    localparam logic [NCOL-1:0] RST_COL   = dec_col(RST_C);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] cur_q, cur_d;
    logic [WORD_W-1:0] tgt_q, tgt_d;
    logic              step_q, step_d;
    logic [NROW-1:0]   r_all_q, r_all_d;
    logic [NROW-1:0]   row_q, row_d;
    logic [NCOL-1:0]   col_q, col_d;

    logic              rdy;
    logic              accept;
    logic [WORD_W-1:0] target;
    logic [WORD_W-1:0] mag;
    logic              up;
    logic              limit;

    assign rdy    = (cur_q == tgt_q);
    assign accept = en_i & word_vld_i & rdy;
    // On an accept edge the first step is taken toward the incoming word.
    assign target = accept ? word_i : tgt_q;
    assign up     = (target >= cur_q);
    assign mag    = up ? (target - cur_q) : (cur_q - target);
    // Only clamp when the remaining distance exceeds the step size, so a
    // step can never overshoot target (and therefore never wraps).
    assign limit  = (MAX_STEP != 0) && (int'(mag) > MAX_STEP);

    always_comb begin
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        step_d  = 1'b0;
        r_all_d = r_all_q;
        row_d   = row_q;
        col_d   = col_q;
        if (en_i) begin
            tgt_d = target;
            if (limit) begin
                cur_d = up ? (cur_q + STEP_C) : (cur_q - STEP_C);
            end else begin
                cur_d = target;
            end
            step_d  = (cur_d != cur_q);
            // Outputs decode the next code so they track cur_word every cycle.
            r_all_d = dec_r_all(cur_d);
            row_d   = dec_row(cur_d);
            col_d   = dec_col(cur_d);
        end
    end

    always_ff @(negedge clk_i) begin
        if (!rst_ni) begin
            cur_q   <= RST_C;
            tgt_q   <= RST_C;
            step_q  <= 1'b0;
            r_all_q <= RST_R_ALL;
            row_q   <= RST_ROW;
            col_q   <= RST_COL;
        end else begin
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            r_all_q <= r_all_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign word_rdy_o = rdy;
    assign busy_o     = ~rdy;
    assign step_o     = step_q;
    assign cur_word_o = cur_q;
    assign r_all_o    = r_all_q;
    assign row_o      = row_q;
    assign col_o      = col_q;

endmodule

// File: tb/tb_dco_bank_slew_cod.sv
// -----------------------------------------------------------------------------
// tb_dco_bank_slew_cod
//
// Two instances: dut_a with default parameters (MAX_STEP = 16) and dut_b with
// MAX_STEP = 0. A reference model tracks the applied code and target with
// integer arithmetic; expected decodes come from shift/mask formulas.
// Directed cases first, then randomized stimulus.
// -----------------------------------------------------------------------------
module tb_dco_bank_slew_cod;

    localparam int NR  = 16;
    localparam int NC  = 16;
    localparam int RST = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en;
    logic       vld_a, vld_b;
    logic [7:0] word_a, word_b;

    logic        rdy_a, busy_a, step_a;
    logic [7:0]  cur_a;
    logic [15:0] r_all_a, row_a, col_a;
    logic        rdy_b, busy_b, step_b;
    logic [7:0]  cur_b;
    logic [15:0] r_all_b, row_b, col_b;

    dco_bank_slew_cod dut_a (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .word_vld_i (vld_a),
        .word_i     (word_a),
        .word_rdy_o (rdy_a),
        .busy_o     (busy_a),
        .step_o     (step_a),
        .cur_word_o (cur_a),
        .r_all_o    (r_all_a),
        .row_o      (row_a),
        .col_o      (col_a)
    );

    dco_bank_slew_cod #(.MAX_STEP(0)) dut_b (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .word_vld_i (vld_b),
        .word_i     (word_b),
        .word_rdy_o (rdy_b),
        .busy_o     (busy_b),
        .step_o     (step_b),
        .cur_word_o (cur_b),
        .r_all_o    (r_all_b),
        .row_o      (row_b),
        .col_o      (col_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int cur_m [2];
    int tgt_m [2];
    int stp_m [2];

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected decodes by arithmetic on the code value.
    function automatic int exp_r_all(input int c);
        return ((1 << NR) - 1) & ~((1 << (c / NC)) - 1);
    endfunction

    function automatic int exp_row(input int c);
        return 1 << (c / NC);
    endfunction

    function automatic int exp_col(input int c);
        int cc, m;
        cc = c % NC;
        m  = (1 << cc) - 1;
        if (((c / NC) % 2) == 0) return m;
        return (m << (NC - cc)) & ((1 << NC) - 1);
    endfunction

    task automatic model_edge(input int k, input int ms, input bit v, input int w);
        int target, d, nxt;
        if (!rst_n) begin
            cur_m[k] = RST;
            tgt_m[k] = RST;
            stp_m[k] = 0;
        end else if (en) begin
            target = (v && cur_m[k] == tgt_m[k]) ? w : tgt_m[k];
            d = target - cur_m[k];
            if (ms == 0 || (d <= ms && d >= -ms)) nxt = target;
            else if (d > 0) nxt = cur_m[k] + ms;
            else nxt = cur_m[k] - ms;
            stp_m[k] = (nxt != cur_m[k]) ? 1 : 0;
            tgt_m[k] = target;
            cur_m[k] = nxt;
        end else begin
            stp_m[k] = 0;
        end
    endtask

    task automatic check_all;
        int r;
        r = (cur_m[0] == tgt_m[0]) ? 1 : 0;
        check_val("a.cur",  int'(cur_a),   cur_m[0]);
        check_val("a.rall", int'(r_all_a), exp_r_all(cur_m[0]));
        check_val("a.row",  int'(row_a),   exp_row(cur_m[0]));
        check_val("a.col",  int'(col_a),   exp_col(cur_m[0]));
        check_val("a.rdy",  int'(rdy_a),   r);
        check_val("a.busy", int'(busy_a),  1 - r);
        check_val("a.step", int'(step_a),  stp_m[0]);
        r = (cur_m[1] == tgt_m[1]) ? 1 : 0;
        check_val("b.cur",  int'(cur_b),   cur_m[1]);
        check_val("b.rall", int'(r_all_b), exp_r_all(cur_m[1]));
        check_val("b.row",  int'(row_b),   exp_row(cur_m[1]));
        check_val("b.col",  int'(col_b),   exp_col(cur_m[1]));
        check_val("b.rdy",  int'(rdy_b),   r);
        check_val("b.busy", int'(busy_b),  1 - r);
        check_val("b.step", int'(step_b),  stp_m[1]);
    endtask

    // One falling (update) edge: advance model, then sample 1 ns later.
    task automatic tick;
        @(negedge clk);
        model_edge(0, 16, vld_a, int'(word_a));
        model_edge(1, 0,  vld_b, int'(word_b));
        #1;
        check_all();
        $display("edge t=%0t rst_n=%0b en=%0b a:vld=%0b w=%02h cur=%02h step=%0b rdy=%0b | b:vld=%0b w=%02h cur=%02h",
                 $time, rst_n, en, vld_a, word_a, cur_a, step_a, rdy_a, vld_b, word_b, cur_b);
    endtask

    initial begin
        cur_m[0] = 0; cur_m[1] = 0; tgt_m[0] = 0; tgt_m[1] = 0;
        stp_m[0] = 0; stp_m[1] = 0;
        rst_n = 1'b0; en = 1'b1;
        vld_a = 1'b0; vld_b = 1'b0; word_a = '0; word_b = '0;

        // Reset held for two edges.
        tick(); tick();
        check_val("rst.rall", int'(r_all_a), 'hFF00);
        check_val("rst.row",  int'(row_a),   'h0100);
        check_val("rst.col",  int'(col_a),   'h0000);
        check_val("rst.cur",  int'(cur_a),   'h80);
        check_val("rst.rdy",  int'(rdy_a),   1);
        check_val("rst.step", int'(step_a),  0);
        rst_n = 1'b1;

        // Accepting the current code: no step, stays ready.
        vld_a = 1'b1; word_a = 8'h80;
        tick();
        check_val("same.step", int'(step_a), 0);
        check_val("same.rdy",  int'(rdy_a),  1);

        // Up slew to 0x93.
        word_a = 8'h93;
        tick();
        vld_a = 1'b0;
        check_val("up.cur1",  int'(cur_a),  'h90);
        check_val("up.busy1", int'(busy_a), 1);
        tick();
        check_val("up.cur2",  int'(cur_a),   'h93);
        check_val("up.step2", int'(step_a),  1);
        check_val("up.rall",  int'(r_all_a), 'hFE00);
        check_val("up.row",   int'(row_a),   'h0200);
        check_val("up.col",   int'(col_a),   'hE000);

        // Down slew from 0x80 to 0x25 with ignored vld and an en stall.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        vld_a = 1'b1; word_a = 8'h25;
        tick();
        word_a = 8'hFF;
        tick();
        check_val("dn.ign.cur", int'(cur_a), 'h60);
        check_val("dn.ign.rdy", int'(rdy_a), 0);
        vld_a = 1'b0;
        en = 1'b0;
        tick(); tick(); tick();
        check_val("dn.stall.cur",  int'(cur_a),  'h60);
        check_val("dn.stall.step", int'(step_a), 0);
        en = 1'b1;
        tick(); tick(); tick(); tick();
        check_val("dn.cur",  int'(cur_a),   'h25);
        check_val("dn.rall", int'(r_all_a), 'hFFFC);
        check_val("dn.row",  int'(row_a),   'h0004);
        check_val("dn.col",  int'(col_a),   'h001F);
        check_val("dn.rdy",  int'(rdy_a),   1);

        // Reset mid-slew discards the target.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        vld_a = 1'b1; word_a = 8'h10;
        tick();
        vld_a = 1'b0;
        tick();
        rst_n = 1'b0; vld_a = 1'b1; word_a = 8'hF0;
        tick();
        rst_n = 1'b1; vld_a = 1'b0;
        check_val("mid.cur",  int'(cur_a),   'h80);
        check_val("mid.rall", int'(r_all_a), 'hFF00);
        tick();
        check_val("mid.hold", int'(cur_a), 'h80);
        check_val("mid.rdy",  int'(rdy_a), 1);

        // Unlimited step instance: full-scale jumps in one edge.
        vld_b = 1'b1; word_b = 8'hFF;
        tick();
        check_val("u.ff.rall", int'(r_all_b), 'h8000);
        check_val("u.ff.row",  int'(row_b),   'h8000);
        check_val("u.ff.col",  int'(col_b),   'hFFFE);
        word_b = 8'h00;
        tick();
        check_val("u.00.rall", int'(r_all_b), 'hFFFF);
        check_val("u.00.row",  int'(row_b),   'h0001);
        check_val("u.00.col",  int'(col_b),   'h0000);
        vld_b = 1'b0;

        // Randomized stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            en     = ($urandom_range(0, 7) != 0);
            vld_a  = ($urandom_range(0, 2) == 0);
            vld_b  = ($urandom_range(0, 2) == 0);
            word_a = 8'($urandom);
            word_b = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
